shift_seq_unit: RTL and testbench

Multi-cycle shift unit for the execute stage. Consumes the 5-bit shift amount produced by the low-bit extraction of a register operand (variable shifts `sllv`/`srlv`/`srav`/`rotrv`) or the instruction `shamt` field. It shifts a 32-bit operand one bit position per cycle under a start/busy/done handshake. The stall logic uses `Busy` to hold the pipeline. The writeback mux takes `Result` when `Done` pulses.

---
 rtl/shift_seq_unit_if.sv | 29 ++
 rtl/shift_seq_unit.sv | 99 +++++++++
 tb/tb_shift_seq_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_unit_if.sv
// Bus between the execute-stage issue logic and the multi-cycle shift unit.
//
// Handshake: a request is accepted on a rising edge where Start=1 and
// Busy=0; Op/A/Shamt are sampled on that same edge. Start is ignored
// while Busy=1, with no queueing. Completion is a single-cycle Done pulse
// and Result is valid in that cycle. Result then holds until the next Done.
interface shift_seq_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [SHW-1:0]   Shamt;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             state_dbg;   // 1 while the unit is in RUN

    modport master (
        output Start, Op, A, Shamt,
        input  Busy, Done, Result, state_dbg
    );

    modport slave (
        input  Start, Op, A, Shamt,
        output Busy, Done, Result, state_dbg
    );
endinterface

// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: one bit position per cycle for sll/srl/sra/rotr.
// A zero shift amount completes directly from IDLE with a one-cycle Done.
module shift_seq_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic           clk,
    input  logic           reset,
    shift_seq_unit_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    state_t           state, state_n;
    logic [WIDTH-1:0] w, w_n;
    logic [SHW-1:0]   cnt, cnt_n;
    logic [1:0]       opr, opr_n;
    logic [WIDTH-1:0] result, result_n;
    logic             done, done_n;
    logic [WIDTH-1:0] w_step;

    // One-bit step of the working register for the latched operation.
    always_comb begin
        w_step = w;
        case (opr)
            OP_SLL:  w_step = {w[WIDTH-2:0], 1'b0};
            OP_SRL:  w_step = {1'b0, w[WIDTH-1:1]};
            OP_SRA:  w_step = {w[WIDTH-1], w[WIDTH-1:1]};
            OP_ROTR: w_step = {w[0], w[WIDTH-1:1]};
            default: w_step = w;
        endcase
    end

    // Next-state and datapath-next logic; Done defaults low so it only pulses.
    always_comb begin
        state_n  = state;
        w_n      = w;
        cnt_n    = cnt;
        opr_n    = opr;
        result_n = result;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    if (bus.Shamt == '0) begin
                        result_n = bus.A;
                        done_n   = 1'b1;
                    end else begin
                        w_n     = bus.A;
                        cnt_n   = bus.Shamt;
                        opr_n   = bus.Op;
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                w_n   = w_step;
                cnt_n = cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    result_n = w_step;
                    done_n   = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            w      <= '0;
            cnt    <= '0;
            opr    <= OP_SLL;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            w      <= w_n;
            cnt    <= cnt_n;
            opr    <= opr_n;
            result <= result_n;
            done   <= done_n;
        end
    end

    assign bus.Busy      = (state == RUN);
    assign bus.Done      = done;
    assign bus.Result    = result;
    assign bus.state_dbg = (state == RUN);
endmodule

// File: tb/tb_shift_seq_unit.sv
// Bench for shift_seq_unit: scenario tasks with inline timing checks and a
// result scoreboard that pops expected values whenever Done pulses.
module tb_shift_seq_unit;
    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic clk;
    logic rst;
    logic rst_at_edge;

    int n_checks;
    int n_fail;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] prev_result;

    shift_seq_unit_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    shift_seq_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial rst_at_edge = 1'b1;
    always @(posedge clk) rst_at_edge <= rst;

    // ---------------- reference model ----------------
    function automatic logic [WIDTH-1:0] model(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input int n);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = a << n;
            2'b01:   r = a >> n;
            2'b10:   r = $unsigned($signed(a) >>> n);
            default: r = (n == 0) ? a : ((a >> n) | (a << (WIDTH - n)));
        endcase
        return r;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (bus.Done === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: Result=%h, no operation outstanding", bus.Result);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (bus.Result !== e) begin
                    n_fail++;
                    $display("FAIL sb_result: got %h expected %h", bus.Result, e);
                end
            end
        end else if (!rst_at_edge) begin
            n_checks++;
            if (bus.Result !== prev_result) begin
                n_fail++;
                $display("FAIL result_stable: got %h expected %h (no Done, no reset)",
                         bus.Result, prev_result);
            end
        end
        prev_result = bus.Result;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in the current cycle (cycle 0); returns in cycle 1.
    task automatic drive_start(input logic [1:0] op, input logic [WIDTH-1:0] a, input int n);
        logic [31:0] nn;
        nn        = n;
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.Shamt = nn[SHW-1:0];
        step();
        bus.Start = 1'b0;
        bus.Op    = 2'($urandom_range(0, 3));
        bus.A     = $urandom;
        bus.Shamt = SHW'($urandom_range(0, 31));
    endtask

    // Full operation with timing checks; returns in the Done cycle (n+1).
    task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input int n, input logic [WIDTH-1:0] exp);
        exp_q.push_back(exp);
        drive_start(op, a, n);
        for (int k = 1; k <= n; k++) begin
            n_checks++;
            if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_window: cycle %0d Busy=%b Done=%b expected Busy=1 Done=0 (op=%0d n=%0d)",
                         k, bus.Busy, bus.Done, op, n);
            end
            step();
        end
        n_checks++;
        if (bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_cycle: cycle %0d Done=%b Busy=%b expected Done=1 Busy=0 (op=%0d n=%0d)",
                     n + 1, bus.Done, bus.Busy, op, n);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst       = 1'b1;
        bus.Start = 1'b0;
        bus.Op    = 2'b00;
        bus.A     = '0;
        bus.Shamt = '0;
        step();
        step();
        n_checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Result !== 32'h0 || bus.state_dbg !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: Busy=%b Done=%b Result=%h state=%b expected 0/0/00000000/0",
                     bus.Busy, bus.Done, bus.Result, bus.state_dbg);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_sll_max();
        run_op(2'b00, 32'h0000_0001, 31, 32'h8000_0000);
        step();
    endtask

    task automatic test_sra_srl();
        run_op(2'b10, 32'h8000_0000, 4, 32'hF800_0000);
        step();
        run_op(2'b01, 32'h8000_0000, 4, 32'h0800_0000);
        step();
    endtask

    task automatic test_rotr_zero();
        run_op(2'b11, 32'h1234_5678, 8, 32'h7812_3456);
        step();
        run_op(2'b11, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
        n_checks++;
        if (bus.Result !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL zero_shift_result: got %h expected deadbeef", bus.Result);
        end
        step();
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(32'h0000_000F);
        drive_start(2'b01, 32'h0000_00F0, 4);
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_busy: cycle %0d Busy=%b Done=%b expected 1/0", k, bus.Busy, bus.Done);
            end
            if (k == 2) begin
                bus.Start = 1'b1;
                bus.Op    = 2'b00;
                bus.A     = 32'hFFFF_FFFF;
                bus.Shamt = 5'd3;
            end else begin
                bus.Start = 1'b0;
            end
            step();
        end
        bus.Start = 1'b0;
        n_checks++;
        if (bus.Done !== 1'b1 || bus.Result !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL b2b_first: Done=%b Result=%h expected 1/0000000f", bus.Done, bus.Result);
        end
        // Second request issued in the Done cycle.
        run_op(2'b00, 32'hFFFF_FFFF, 3, 32'hFFFF_FFF8);
        step();
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(32'h0);
        drive_start(2'b00, 32'hA5A5_A5A5, 9);
        step();
        step();
        // Cycle 3: reset together with a Start that must be ignored.
        rst       = 1'b1;
        bus.Start = 1'b1;
        bus.Op    = 2'b01;
        bus.A     = 32'h1111_1111;
        bus.Shamt = 5'd5;
        exp_q.delete();
        step();
        rst       = 1'b0;
        bus.Start = 1'b0;
        n_checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: Busy=%b Done=%b Result=%h expected 0/0/00000000",
                     bus.Busy, bus.Done, bus.Result);
        end
        for (int k = 0; k < 12; k++) begin
            n_checks++;
            if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_abort: cycle +%0d Done=%b Busy=%b expected 0/0", k, bus.Done, bus.Busy);
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [1:0]       op;
            logic [WIDTH-1:0] a;
            int               n;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            n  = $urandom_range(0, 31);
            run_op(op, a, n, model(op, a, n));
            if ($urandom_range(0, 1) == 1) step();
        end
        step();
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        n_checks    = 0;
        n_fail      = 0;
        prev_result = '0;
        rst         = 1'b1;
        bus.Start   = 1'b0;
        bus.Op      = 2'b00;
        bus.A       = '0;
        bus.Shamt   = '0;
        #1;
        test_reset();
        test_sll_max();
        test_sra_srl();
        test_rotr_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_reset();
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected results never produced, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
